exibe_sequencia: RTL
====================

# exibe_sequencia

Sequence-presentation controller for the memory game: reads the stored sequence out of the game's synchronous ROM and flashes each element on the LED outputs with fixed on/off intervals. It is the outbound counterpart of the play-checking control unit, which consumes the player's jogadas. The top level starts this block before each round's espera_jogada phase and waits for `pronto`.

## Interface
- `ADDR_W`, 4: ROM address width; the sequence holds at most 2^ADDR_W elements.
- `DATA_W`, 4: ROM word and LED width.
- `ON_CYCLES`, 3: cycles each element is lit. Must be ≥1.
- `OFF_CYCLES`, 2: dark cycles after each element. Must be ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `iniciar` in 1: level start request.
- `limite` in ADDR_W: index of the last element to show; sampled in preparacao.
- `mem_dado` in DATA_W: ROM read data, valid one cycle after the address.
- `mem_endereco` out ADDR_W: ROM read address.
- `leds` out DATA_W: displayed element; 0 when dark.
- `ocupado` out 1: high in every state except inicial and final_exibicao.
- `pronto` out 1: high only in final_exibicao.
- `db_estado` out 4: state code for the 7-segment debug display.
- `pausa` in 1: present only with `EXIBE_PAUSA_EN`.

## Operation
- Moore FSM. States and db_estado codes:
  - inicial 0
  - preparacao 1
  - carrega 2
  - acende 3
  - apaga 4
  - proximo 5
  - final_exibicao E
  - Any illegal state shows 3 and returns to inicial.
- Transitions:
  - inicial → preparacao when iniciar=1.
  - preparacao → carrega. Clears the address counter, latches limite, clears the timer.
  - carrega → acende. ROM address presented.
  - acende → apaga after ON_CYCLES cycles. On entry, mem_dado is registered into leds.
  - apaga → final_exibicao if address == latched limite; otherwise apaga → proximo. Runs OFF_CYCLES cycles with leds=0.
  - proximo → carrega. Address +1.
  - final_exibicao → preparacao when iniciar=1.
- iniciar is ignored in all other states. Holding iniciar high in final_exibicao restarts the sequence immediately.
- Address counter does not wrap within a run, because limite ≤ 2^ADDR_W−1 bounds it.
- limite=0 shows exactly one element.
- Reset at any point: inicial, all outputs 0, timer and address cleared. No partial element remains lit.

## Timing
- Reset values: leds=0, mem_endereco=0, ocupado=0, pronto=0, db_estado=0.
- Edge numbering: edge 0 is the edge that samples iniciar=1.
  - ocupado rises after edge 0.
  - Element 0 is lit after edge 2.
- Per element: carrega 1 + acende ON_CYCLES + apaga OFF_CYCLES cycles, plus proximo 1 cycle between elements.
- Total run for N = limite+1 elements: final_exibicao is entered N·(ON_CYCLES+OFF_CYCLES+2) edges after edge 0. pronto and ocupado=0 take effect at that same edge.
- Timer: down-counter loaded with ON_CYCLES−1 (or OFF_CYCLES−1) on state entry. The state exits when the counter reads 0.

## Configuration
- `EXIBE_PAUSA_EN` defined:
  - Adds input `pausa`.
  - While pausa=1 in acende or apaga, the timer and state hold, and leds keeps its value.
  - Pausa has no effect in any other state.
  - Total run length grows by exactly the number of paused cycles inside acende/apaga.
- Undefined: no `pausa` port; timing exactly as above.

## Structure
- Shared package (`exibe_pkg`):
  - State encodings.
  - db_estado codes, including the 3 = error code.
  - The `ERRO` default constant.
- One sub-module, `temporizador_exibicao`:
  - Parametric down-counter with `carrega`, `valor`, `conta`, `zero`.
  - Width clog2(max(ON_CYCLES,OFF_CYCLES)), minimum 1.
- Address counter and LED register stay inline.

## Test plan
- Reset → all outputs 0, db_estado=0. Pulse iniciar with limite=1, ON=3, OFF=2, ROM = {5, A} → leds: 5 for 3 cycles, 0 for 2, 0 for 2 more cycles (proximo, carrega), A for 3, 0 for 2. pronto rises at edge 14.
- limite=0, ROM[0]=F → one flash of F. pronto at edge 7. mem_endereco never leaves 0.
- limite=15, ROM = 0..F → 16 flashes in address order. pronto at edge 112. No address wrap.
- Assert reset (low) during the 2nd acende → leds=0 and state inicial immediately, asynchronously. A new iniciar replays from element 0.
- In final_exibicao, hold iniciar high → preparacao next cycle (db_estado 1). iniciar pulses mid-run leave the timing unchanged.
- With EXIBE_PAUSA_EN, 4-cycle pausa during acende of element 0 (limite=0) → that element is lit for 7 cycles. pronto at edge 11.

Source files
------------

// File: rtl/exibe_pkg.sv
// Shared definitions for the sequence-presentation controller: state encodings,
// 7-segment debug codes and the timer width helper.
package exibe_pkg;

  typedef enum logic [2:0] {
    ST_INICIAL    = 3'd0,
    ST_PREPARACAO = 3'd1,
    ST_CARREGA    = 3'd2,
    ST_ACENDE     = 3'd3,
    ST_APAGA      = 3'd4,
    ST_PROXIMO    = 3'd5,
    ST_FINAL      = 3'd6
  } estado_t;

  localparam logic [3:0] DB_INICIAL    = 4'h0;
  localparam logic [3:0] DB_PREPARACAO = 4'h1;
  localparam logic [3:0] DB_CARREGA    = 4'h2;
  localparam logic [3:0] DB_ACENDE     = 4'h3;
  localparam logic [3:0] DB_APAGA      = 4'h4;
  localparam logic [3:0] DB_PROXIMO    = 4'h5;
  localparam logic [3:0] DB_FINAL      = 4'hE;
  localparam logic [3:0] ERRO          = 4'h3;

  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// Loadable down-counter that times the lit and dark intervals of each element.
module temporizador_exibicao #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic         conta,
  input  logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   cnt <= '0;
    else if (carrega)             cnt <= valor;
    else if (conta && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Reads the stored sequence from the game ROM and flashes each element on the LEDs.
// Optional build macro EXIBE_PAUSA_EN adds a pausa input that freezes the lit/dark timing.
import exibe_pkg::*;

module exibe_sequencia #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYCLES  = 3,
  parameter int OFF_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] mem_dado,
`ifdef EXIBE_PAUSA_EN
  input  logic              pausa,
`endif
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int TW = tmr_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_V  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_V = TW'(OFF_CYCLES - 1);

  estado_t state, next;
  logic [ADDR_W-1:0] lim_q;
  logic [TW-1:0] t_val;
  logic t_load, t_conta, t_zero, hold;
  logic clr_end, inc_end, lat_lim, ld_leds, clr_leds;

`ifdef EXIBE_PAUSA_EN
  assign hold = pausa;
`else
  assign hold = 1'b0;
`endif

  temporizador_exibicao #(.W(TW)) u_tmr (
    .clock  (clock),
    .reset  (reset),
    .carrega(t_load),
    .conta  (t_conta),
    .valor  (t_val),
    .zero   (t_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_INICIAL;
    else        state <= next;
  end

  // Address moves on entry to preparacao/proximo so the synchronous ROM has
  // data ready by the carrega->acende edge.
  always_comb begin
    next      = state;
    t_load    = 1'b0;
    t_val     = '0;
    t_conta   = 1'b0;
    clr_end   = 1'b0;
    inc_end   = 1'b0;
    lat_lim   = 1'b0;
    ld_leds   = 1'b0;
    clr_leds  = 1'b0;
    ocupado   = 1'b1;
    pronto    = 1'b0;
    db_estado = ERRO;
    case (state)
      ST_INICIAL: begin
        ocupado   = 1'b0;
        db_estado = DB_INICIAL;
        if (iniciar) begin
          next    = ST_PREPARACAO;
          clr_end = 1'b1;
        end
      end
      ST_PREPARACAO: begin
        db_estado = DB_PREPARACAO;
        next      = ST_CARREGA;
        lat_lim   = 1'b1;
        t_load    = 1'b1;
      end
      ST_CARREGA: begin
        db_estado = DB_CARREGA;
        next      = ST_ACENDE;
        t_load    = 1'b1;
        t_val     = ON_V;
        ld_leds   = 1'b1;
      end
      ST_ACENDE: begin
        db_estado = DB_ACENDE;
        if (!hold) begin
          if (t_zero) begin
            next     = ST_APAGA;
            t_load   = 1'b1;
            t_val    = OFF_V;
            clr_leds = 1'b1;
          end else begin
            t_conta = 1'b1;
          end
        end
      end
      ST_APAGA: begin
        db_estado = DB_APAGA;
        if (!hold) begin
          if (t_zero) begin
            if (mem_endereco == lim_q) begin
              next = ST_FINAL;
            end else begin
              next    = ST_PROXIMO;
              inc_end = 1'b1;
            end
          end else begin
            t_conta = 1'b1;
          end
        end
      end
      ST_PROXIMO: begin
        db_estado = DB_PROXIMO;
        next      = ST_CARREGA;
      end
      ST_FINAL: begin
        ocupado   = 1'b0;
        pronto    = 1'b1;
        db_estado = DB_FINAL;
        if (iniciar) begin
          next    = ST_PREPARACAO;
          clr_end = 1'b1;
        end
      end
      default: begin
        next     = ST_INICIAL;
        clr_leds = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_endereco <= '0;
      lim_q        <= '0;
      leds         <= '0;
    end else begin
      if (clr_end)      mem_endereco <= '0;
      else if (inc_end) mem_endereco <= mem_endereco + 1'b1;
      if (lat_lim)      lim_q <= limite;
      if (ld_leds)      leds <= mem_dado;
      else if (clr_leds) leds <= '0;
    end
  end

endmodule
